reg_bus_arbiter: RTL and testbench



---
 rtl/reg_bus_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 26 ++
 rtl/reg_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and widths for the register-bus arbiter slice.
// Imported by the arbiter top and its round-robin picker.
package reg_bus_pkg;

    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } ArbState;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] wdata;
    } RegReq;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time
// gets the bus; otherwise the sole requester wins.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic grant_o,
    output logic valid_o,
    output logic contended_o
);

    // Grant selection and tie detection
    always_comb begin
        valid_o     = req0_i | req1_i;
        contended_o = req0_i & req1_i;
        grant_o     = 1'b0;
        if (contended_o) begin
            grant_o = ~last_gnt_i;
        end else if (req1_i) begin
            grant_o = 1'b1;
        end else begin
            grant_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Serialises two requesters onto a single-ported register bus with a one-cycle
// write strobe and a registered (one-cycle latency) read path.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              gnt_id,
    output logic              busy,
    output logic [CNT_W-1:0]  contention_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ArbState           state_q;
    logic              last_gnt_q;
    logic              gnt_q;
    logic              we_q;
    logic              busy_q;
    logic              bus_we_q;
    logic              r0_ack_q;
    logic              r1_ack_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [DATA_W-1:0] r0_rdata_q;
    logic [DATA_W-1:0] r1_rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              pick_gnt_s;
    logic              pick_valid_s;
    logic              pick_cont_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    rr_pick2 u_pick (
        .req0_i      (r0_req),
        .req1_i      (r1_req),
        .last_gnt_i  (last_gnt_q),
        .grant_o     (pick_gnt_s),
        .valid_o     (pick_valid_s),
        .contended_o (pick_cont_s)
    );

    // Route the winning requester's transaction fields
    always_comb begin
        sel_we_s    = r0_we;
        sel_addr_s  = r0_addr;
        sel_wdata_s = r0_wdata;
        if (pick_gnt_s) begin
            sel_we_s    = r1_we;
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
        end else begin
            sel_we_s    = r0_we;
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
        end
    end

    // Saturating increment on every tie seen while IDLE
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) && pick_cont_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Contention counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Access sequencer; every bus-facing output is a register of this FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            bus_we_q    <= 1'b0;
            r0_ack_q    <= 1'b0;
            r1_ack_q    <= 1'b0;
            bus_addr_q  <= {ADDR_W{1'b0}};
            bus_wdata_q <= {DATA_W{1'b0}};
            r0_rdata_q  <= {DATA_W{1'b0}};
            r1_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    r0_ack_q <= 1'b0;
                    r1_ack_q <= 1'b0;
                    if (pick_valid_s) begin
                        bus_addr_q  <= sel_addr_s;
                        bus_wdata_q <= sel_wdata_s;
                        bus_we_q    <= sel_we_s;
                        we_q        <= sel_we_s;
                        gnt_q       <= pick_gnt_s;
                        last_gnt_q  <= pick_gnt_s;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end else begin
                        bus_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                ISSUE: begin
                    // The strobe lives for this single cycle only
                    bus_we_q <= 1'b0;
                    if (we_q) begin
                        r0_ack_q <= ~gnt_q;
                        r1_ack_q <= gnt_q;
                        state_q  <= ACK;
                    end else begin
                        state_q  <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (gnt_q) begin
                        r1_rdata_q <= bus_rdata;
                    end else begin
                        r0_rdata_q <= bus_rdata;
                    end
                    r0_ack_q <= ~gnt_q;
                    r1_ack_q <= gnt_q;
                    state_q  <= ACK;
                end
                ACK: begin
                    r0_ack_q <= 1'b0;
                    r1_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    bus_we_q <= 1'b0;
                    r0_ack_q <= 1'b0;
                    r1_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus_addr         = bus_addr_q;
    assign bus_wdata        = bus_wdata_q;
    assign bus_we           = bus_we_q;
    assign r0_ack           = r0_ack_q;
    assign r1_ack           = r1_ack_q;
    assign r0_rdata         = r0_rdata_q;
    assign r1_rdata         = r1_rdata_q;
    assign gnt_id           = gnt_q;
    assign busy             = busy_q;
    assign contention_count = cnt_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level timing/round-robin model.
module tb_reg_bus_arbiter;

    localparam int NC = 8192;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rf_init;
    logic       r0_req, r0_we, r0_ack, r1_req, r1_we, r1_ack;
    logic [7:0] r0_addr, r0_wdata, r0_rdata, r1_addr, r1_wdata, r1_rdata;
    logic [7:0] bus_addr, bus_wdata, bus_rdata;
    logic       bus_we, gnt_id, busy;
    logic [15:0] contention_count;
    logic       s_r0_ack, s_r1_ack, s_bus_we, s_gnt_id, s_busy;
    logic [7:0] s_r0_rdata, s_r1_rdata, s_bus_addr, s_bus_wdata;
    logic [3:0] s_cnt;
    logic [7:0] rf_mem [256];

    always #5 clk = ~clk;

    reg_bus_arbiter u_dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata),
        .gnt_id(gnt_id), .busy(busy), .contention_count(contention_count)
    );

    // Narrow-counter instance so saturation is reachable in a short run
    reg_bus_arbiter #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(s_r0_ack), .r0_rdata(s_r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(s_r1_ack), .r1_rdata(s_r1_rdata),
        .bus_addr(s_bus_addr), .bus_wdata(s_bus_wdata), .bus_we(s_bus_we), .bus_rdata(bus_rdata),
        .gnt_id(s_gnt_id), .busy(s_busy), .contention_count(s_cnt)
    );

    function automatic logic [7:0] rf_seed(input int i);
        if (i == 32'hB3) return 8'h5A;
        return 8'((i * 37) + 11);
    endfunction

    // Register-file model: registered read, write on writeEn
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 256; i++) rf_mem[i] <= rf_seed(i);
        end else if (bus_we) begin
            rf_mem[bus_addr] <= bus_wdata;
        end
        bus_rdata <= rf_mem[bus_addr];
    end

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         m_free, m_cnt;
    logic       m_last;
    logic [7:0] m_rd0, m_rd1;
    logic [7:0] ref_mem [256];
    logic [7:0] undo_addr, undo_val;
    bit         undo_ok;
    bit         rand_mode = 1'b0;
    txn_t       q0[$];
    txn_t       q1[$];

    logic       e_ack0 [NC];
    logic       e_ack1 [NC];
    logic       e_we   [NC];
    logic       e_av   [NC];
    logic       e_busy [NC];
    logic       e_gnt  [NC];
    logic       e_rdv0 [NC];
    logic       e_rdv1 [NC];
    logic [7:0] e_addr [NC];
    logic [7:0] e_wdata[NC];
    logic [7:0] e_rd0  [NC];
    logic [7:0] e_rd1  [NC];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        return mk(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            e_ack0[i] = 1'b0; e_ack1[i] = 1'b0; e_we[i] = 1'b0; e_av[i] = 1'b0;
            e_busy[i] = 1'b0; e_gnt[i] = 1'b0; e_rdv0[i] = 1'b0; e_rdv1[i] = 1'b0;
            e_addr[i] = 8'h00; e_wdata[i] = 8'h00; e_rd0[i] = 8'h00; e_rd1[i] = 8'h00;
        end
        m_free = cyc + 1; m_cnt = 0; m_last = 1'b1;
        m_rd0 = 8'h00; m_rd1 = 8'h00; undo_ok = 1'b0;
    endtask

    task automatic apply_inputs();
        r0_req = (q0.size() > 0);
        if (r0_req) begin r0_we = q0[0].we; r0_addr = q0[0].addr; r0_wdata = q0[0].wdata; end
        r1_req = (q1.size() > 0);
        if (r1_req) begin r1_we = q1[0].we; r1_addr = q1[0].addr; r1_wdata = q1[0].wdata; end
    endtask

    task automatic compare();
        int sat_exp;
        sat_exp = (m_cnt > 15) ? 15 : m_cnt;
        if (e_rdv0[cyc]) m_rd0 = e_rd0[cyc];
        if (e_rdv1[cyc]) m_rd1 = e_rd1[cyc];
        check_val("r0_ack", r0_ack, e_ack0[cyc]);
        check_val("r1_ack", r1_ack, e_ack1[cyc]);
        check_val("r0_rdata", r0_rdata, m_rd0);
        check_val("r1_rdata", r1_rdata, m_rd1);
        check_val("bus_we", bus_we, e_we[cyc]);
        check_val("busy", busy, e_busy[cyc]);
        check_val("contention", contention_count, m_cnt);
        check_val("sat_cnt", s_cnt, sat_exp);
        check_val("sat_we", s_bus_we, e_we[cyc]);
        check_val("sat_acks", {s_r0_ack, s_r1_ack}, {e_ack0[cyc], e_ack1[cyc]});
        check_val("sat_rdata", {s_r0_rdata, s_r1_rdata}, {m_rd0, m_rd1});
        check_val("sat_busy", s_busy, e_busy[cyc]);
        if (e_av[cyc]) begin
            check_val("bus_addr", bus_addr, e_addr[cyc]);
            check_val("sat_addr", s_bus_addr, e_addr[cyc]);
        end
        if (e_we[cyc]) begin
            check_val("bus_wdata", bus_wdata, e_wdata[cyc]);
            check_val("sat_wdata", s_bus_wdata, e_wdata[cyc]);
        end
        if (e_busy[cyc]) begin
            check_val("gnt_id", gnt_id, e_gnt[cyc]);
            check_val("sat_gnt", s_gnt_id, e_gnt[cyc]);
        end
    endtask

    task automatic drive();
        if (e_ack0[cyc]) void'(q0.pop_front());
        if (e_ack1[cyc]) void'(q1.pop_front());
        if (rand_mode) begin
            if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_txn());
            if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_txn());
        end
        apply_inputs();
    endtask

    // Transaction-level model: when free, pick per round robin and schedule outcomes
    task automatic model();
        logic r0, r1, g;
        txn_t t;
        int   done;
        if (cyc >= m_free) begin
            r0 = (q0.size() > 0);
            r1 = (q1.size() > 0);
            if (r0 || r1) begin
                if (r0 && r1) begin
                    g = ~m_last;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    g = r1;
                end
                m_last = g;
                t = g ? q1[0] : q0[0];
                done = t.we ? cyc + 2 : cyc + 3;
                for (int j = cyc + 1; j <= done; j++) begin
                    e_busy[j] = 1'b1;
                    e_gnt[j]  = g;
                end
                e_av[cyc + 1] = 1'b1;
                e_addr[cyc + 1] = t.addr;
                if (g) e_ack1[done] = 1'b1; else e_ack0[done] = 1'b1;
                if (t.we) begin
                    e_we[cyc + 1] = 1'b1;
                    e_wdata[cyc + 1] = t.wdata;
                    undo_addr = t.addr; undo_val = ref_mem[t.addr]; undo_ok = 1'b1;
                    ref_mem[t.addr] = t.wdata;
                end else begin
                    e_av[cyc + 2] = 1'b1;
                    e_addr[cyc + 2] = t.addr;
                    undo_ok = 1'b0;
                    if (g) begin e_rdv1[done] = 1'b1; e_rd1[done] = ref_mem[t.addr]; end
                    else   begin e_rdv0[done] = 1'b1; e_rd0[done] = ref_mem[t.addr]; end
                end
                m_free = done + 1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc >= NC - 8) begin
            $display("FAIL cycle_budget: got %0d expected < %0d", cyc, NC - 8);
            $fatal(1, "cycle budget exhausted");
        end
        compare();
        drive();
        model();
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cyc < m_free - 1) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) check_val("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset = 1'b1; rf_init = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = rf_seed(i);
        repeat (3) @(negedge clk);
        rf_init = 1'b0;
        check_val("rst_acks", {r0_ack, r1_ack}, 2'b00);
        check_val("rst_rdata", {r0_rdata, r1_rdata}, 16'h0000);
        check_val("rst_bus", {bus_addr, bus_wdata, bus_we}, 17'h00000);
        check_val("rst_gnt_busy", {gnt_id, busy}, 2'b00);
        check_val("rst_cnt", contention_count, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Single write, single read, back-to-back writes from one requester
        q0.push_back(mk(1'b1, 8'h81, 8'h01));
        drain(20);
        q1.push_back(mk(1'b0, 8'hB3, 8'h00));
        drain(20);
        q0.push_back(mk(1'b1, 8'hF0, 8'hAA));
        q0.push_back(mk(1'b1, 8'h82, 8'h10));
        drain(30);

        // Reset while a contended write sits in ISSUE
        q0.push_back(mk(1'b1, 8'h40, 8'h11));
        q1.push_back(mk(1'b1, 8'h41, 8'h22));
        begin
            int n;
            n = 0;
            step();
            while (!e_we[cyc] && n < 20) begin step(); n++; end
            check_val("t5_reached_issue", e_we[cyc], 1'b1);
        end
        check_val("t5_pre_cnt", contention_count, 16'd1);
        reset = 1'b1;
        #1;
        check_val("t5_we_drop", bus_we, 1'b0);
        check_val("t5_acks", {r0_ack, r1_ack}, 2'b00);
        check_val("t5_busy", busy, 1'b0);
        check_val("t5_cnt", contention_count, 16'h0000);
        if (undo_ok) ref_mem[undo_addr] = undo_val;
        q0.delete(); q1.delete();
        apply_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) step();

        // Both requesters held: strict alternation, six contended grants
        for (int i = 0; i < 4; i++) q0.push_back(rand_txn());
        for (int i = 0; i < 3; i++) q1.push_back(rand_txn());
        drain(100);
        check_val("t3_contention", contention_count, 16'd6);

        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        drain(200);
        check_val("sat_hold", s_cnt, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
